gpr_wb_arb: RTL
===============

GPR_WB_ARB -- requirements
Module: gpr_wb_arb

Interface
REQ-001 Parameters: none; requester count fixed at 3, register address width 5, data width 32, all taken from the shared constants.
REQ-002 clk_I  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n_I  input  1  reset, asynchronous and active-low.
REQ-004 req_I  input  3  per-requester write-back valid (bit0 ALU, bit1 load, bit2 mult/div).
REQ-005 wreg_I  input  15  destination register per requester, packed 5 bits each, requester k at [5k+4:5k].
REQ-006 wd_I  input  96  write data per requester, packed 32 bits each, requester k at [32k+31:32k].
REQ-007 gnt_O  output  3  one-hot grant, combinational; accept = req_I[k] & gnt_O[k] at a rising edge.
REQ-008 RegWrite_O  output  1  register-file write enable, registered.
REQ-009 Wreg_O  output  5  register-file write address, registered.
REQ-010 WD_O  output  32  register-file write data, registered.
REQ-011 issue_I  input  1  an instruction with GPR destination issues this cycle.
REQ-012 issue_reg_I  input  5  destination of the issuing instruction.
REQ-013 chk_a_I, chk_b_I  input  5 each  source registers to hazard-check.
REQ-014 busy_a_O, busy_b_O  output  1 each  source has outstanding write, combinational from scoreboard.
REQ-015 err_O  output  1  sticky scoreboard overflow/underflow flag.

Function
REQ-016 Arbitration SHALL be round-robin: search starts at requester after last accepted one; pointer reset value selects requester 0 first.
REQ-017 gnt_O SHALL be zero when req_I is zero, and at most one bit SHALL be set.
REQ-018 Pointer SHALL advance only on accept; a granted but withdrawn request leaves pointer unchanged.
REQ-019 Requester SHALL hold req_I, wreg_I, wd_I stable until accepted; block is always ready, one accept per cycle maximum.
REQ-020 Accept at edge N SHALL produce RegWrite_O=1, Wreg_O, WD_O of winner during cycle N+1 (latency 1); otherwise RegWrite_O=0 and Wreg_O/WD_O hold previous value.
REQ-021 Accept with destination 0 SHALL be consumed (pointer advances) but RegWrite_O SHALL stay 0.
REQ-022 Scoreboard: 2-bit counter per register 1..31; register 0 never busy.
REQ-023 issue_I with issue_reg_I!=0 SHALL increment that counter at the rising edge.
REQ-024 Counter SHALL decrement at the rising edge ending a cycle in which RegWrite_O=1 for that register (write visible in register file from then).
REQ-025 Simultaneous increment and decrement of same register SHALL leave counter unchanged.
REQ-026 busy_x_O = (counter[chk_x_I] != 0); chk_x_I=0 gives 0.
REQ-027 Increment at count 3 or decrement at count 0 SHALL leave counter unchanged and set err_O until reset.

Reset
REQ-028 rst_n_I low SHALL immediately clear RegWrite_O, Wreg_O, WD_O, err_O, all counters, and set pointer to requester 0, including mid-operation; pending accept is discarded.
REQ-029 First accept SHALL be possible at the first rising edge after rst_n_I deasserts.

Structure
REQ-030 Requester count, address width, data width and requester index constants SHALL live in the shared header with the other CPU constants.
REQ-031 One sub-module rr_arb3 (3-way round-robin arbiter with pointer) SHALL be instantiated; scoreboard and output stage stay in gpr_wb_arb.

Verification
REQ-032 Reset asserted mid-write -> RegWrite_O, err_O, busy outputs 0 asynchronously, gnt_O follows req_I from requester 0 priority.
REQ-033 req_I=001, wreg=5, wd=0x00001234 -> gnt_O=001 same cycle; next cycle RegWrite_O=1, Wreg_O=5, WD_O=0x00001234.
REQ-034 req_I=111 held 6 cycles -> gnt_O sequence 001,010,100,001,010,100.
REQ-035 issue reg 8 twice, chk_a_I=8 -> busy_a_O=1 until second write-back of reg 8 retires, then 0; err_O=0.
REQ-036 req_I=010 with wreg=0 -> accepted, RegWrite_O stays 0, next round-robin search starts at requester 2.
REQ-037 issue reg 3 four times without write-back -> counter stays 3, err_O=1 and remains 1 after later write-backs.

Source files
------------

// File: rtl/gpr_wb_arb_pkg.sv
// Shared CPU constants for the GPR write-back path: requester set, register
// file geometry and the scoreboard counter type.
package gpr_wb_arb_pkg;

  localparam int NREQ       = 3;
  localparam int AW         = 5;
  localparam int DW         = 32;
  localparam int NREGS      = 1 << AW;

  localparam int REQ_ALU    = 0;
  localparam int REQ_LOAD   = 1;
  localparam int REQ_MULDIV = 2;

  typedef logic [$clog2(NREQ)-1:0] req_idx_t;
  typedef logic [1:0]              sb_cnt_t;

  localparam sb_cnt_t SB_MAX = 2'd3;

  typedef struct packed {
    logic [AW-1:0] wreg;
    logic [DW-1:0] wd;
  } wb_t;

  // Next requester in round-robin order, wrapping after the last one.
  function automatic req_idx_t rr_next(input req_idx_t idx);
    return (idx == req_idx_t'(REQ_MULDIV)) ? req_idx_t'(REQ_ALU) : idx + req_idx_t'(1);
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter. The pointer holds the requester searched
// first and moves past the winner only when a grant is taken.
module rr_arb3
  import gpr_wb_arb_pkg::*;
(
  input  logic            clk_I,
  input  logic            rst_n_I,
  input  logic [NREQ-1:0] req_I,
  output logic [NREQ-1:0] gnt_O,
  output logic            acc_O
);

  req_idx_t ptr_q;
  req_idx_t idx;
  req_idx_t win;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    gnt_O = '0;
    acc_O = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      if (!acc_O && req_I[idx]) begin
        gnt_O[idx] = 1'b1;
        win        = idx;
        acc_O      = 1'b1;
      end
      idx = rr_next(idx);
    end
  end

  // NOTE: registered state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      ptr_q <= req_idx_t'(REQ_ALU);
    end else if (acc_O) begin
      ptr_q <= rr_next(win);
    end
  end

endmodule

// File: rtl/gpr_wb_arb.sv
// GPR write-back arbiter: picks one of three write-back sources per cycle,
// registers the register-file write, and tracks outstanding writes per register.
module gpr_wb_arb
  import gpr_wb_arb_pkg::*;
(
  input  logic               clk_I,
  input  logic               rst_n_I,
  input  logic [NREQ-1:0]    req_I,
  input  logic [NREQ*AW-1:0] wreg_I,
  input  logic [NREQ*DW-1:0] wd_I,
  output logic [NREQ-1:0]    gnt_O,
  output logic               RegWrite_O,
  output logic [AW-1:0]      Wreg_O,
  output logic [DW-1:0]      WD_O,
  input  logic               issue_I,
  input  logic [AW-1:0]      issue_reg_I,
  input  logic [AW-1:0]      chk_a_I,
  input  logic [AW-1:0]      chk_b_I,
  output logic               busy_a_O,
  output logic               busy_b_O,
  output logic               err_O
);

  logic    accept;
  wb_t     win;
  sb_cnt_t cnt_q [NREGS];
  logic    inc_en, dec_en, same_reg, ovf, unf;

  rr_arb3 u_arb (
    .clk_I   (clk_I),
    .rst_n_I (rst_n_I),
    .req_I   (req_I),
    .gnt_O   (gnt_O),
    .acc_O   (accept)
  );

  always_comb begin
    win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_O[k]) begin
        win.wreg = wreg_I[k*AW +: AW];
        win.wd   = wd_I[k*DW +: DW];
      end
    end
  end

  // An accept targeting r0 is consumed silently; address/data keep their last write.
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      RegWrite_O <= 1'b0;
      Wreg_O     <= '0;
      WD_O       <= '0;
    end else begin
      RegWrite_O <= accept && (win.wreg != '0);
      if (accept && (win.wreg != '0)) begin
        Wreg_O <= win.wreg;
        WD_O   <= win.wd;
      end
    end
  end

  // Issue and retire of the same register in one cycle cancel out.
  always_comb begin
    inc_en   = issue_I && (issue_reg_I != '0);
    dec_en   = RegWrite_O && (Wreg_O != '0);
    same_reg = inc_en && dec_en && (issue_reg_I == Wreg_O);
    ovf      = inc_en && !same_reg && (cnt_q[issue_reg_I] == SB_MAX);
    unf      = dec_en && !same_reg && (cnt_q[Wreg_O] == '0);
  end

  // NOTE: the counter array is cleared by reset because busy_*_O must read 0 straight out of reset.
  always_ff @(posedge clk_I or negedge rst_n_I) begin
    if (!rst_n_I) begin
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
      err_O <= 1'b0;
    end else begin
      err_O <= err_O | ovf | unf;
      if (!same_reg) begin
        if (inc_en && !ovf) cnt_q[issue_reg_I] <= cnt_q[issue_reg_I] + 2'd1;
        if (dec_en && !unf) cnt_q[Wreg_O]      <= cnt_q[Wreg_O] - 2'd1;
      end
    end
  end

  assign busy_a_O = (chk_a_I != '0) && (cnt_q[chk_a_I] != '0);
  assign busy_b_O = (chk_b_I != '0) && (cnt_q[chk_b_I] != '0);

endmodule
